pipe_ctrl_unit: RTL and testbench

//  Parametrised pipeline control unit: NSTAGE-stage successor of the fixed 5-stage acu.
//  Per-stage stall/bubble from a hazard vector, prioritised multi-source redirect with ready handshake,

---
 rtl/pipe_ctrl_unit.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: per-stage stall/bubble generation from a hazard vector,
// prioritised redirect arbitration with a ready handshake, debug halt with drain,
// and a sticky stall watchdog.
module pipe_ctrl_unit #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned NSTAGE     = 5,
   parameter int unsigned EX_STAGE   = 2,
   parameter int unsigned NREDIR     = 2,
   parameter int unsigned WDOG_W     = 16,
   parameter int unsigned WDOG_LIMIT = 1000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NSTAGE-1:0]        stage_hazard,
   input  logic [NSTAGE-1:0]        stage_valid,
   input  logic [NREDIR-1:0]        redir_valid,
   input  logic [NREDIR*ADDR_W-1:0] redir_pc,
   output logic                     redir_ready,
   output logic                     fetch_flush,
   output logic [ADDR_W-1:0]        flush_pc,
   output logic [NSTAGE-1:0]        stage_stall,
   output logic [NSTAGE-1:0]        stage_flush,
   input  logic                     dbg_halt_req,
   input  logic                     dbg_resume_req,
   output logic                     dbg_halted,
   output logic                     wdog_timeout
);

   typedef enum logic [1:0] {StRun, StDrain, StHalted, StResume} state_e;

   localparam logic [WDOG_W-1:0] WdogLast = WDOG_W'(WDOG_LIMIT - 1);

   state_e              state_q;
   logic [WDOG_W-1:0]   wdog_cnt_q;
   logic [NSTAGE:0]     hz_up;
   logic                frz;
   logic                dn_stall;
   logic                any_redir;
   logic [ADDR_W-1:0]   win_pc;
   logic                drained;
   logic                wdog_inc;

   // hz_up[i]: some stage at index i or older is blocked; hz_up[NSTAGE] is the empty case
   always_comb begin
      logic acc;
      acc = 1'b0;
      hz_up = '0;
      for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
         acc      = acc | stage_hazard[i];
         hz_up[i] = acc;
      end
   end

   // Redirect arbitration: the highest-index valid source wins
   always_comb begin
      win_pc    = '0;
      any_redir = |redir_valid;
      for (int k = 0; k < int'(NREDIR); k++) begin
         if (redir_valid[k]) begin
            win_pc = redir_pc[k*ADDR_W +: ADDR_W];
         end
      end
   end

   assign frz      = (state_q == StHalted);
   assign dn_stall = hz_up[EX_STAGE+1] | frz;
   assign drained  = (stage_valid[NSTAGE-1:1] == '0);

   // Stage hold/bubble and redirect outputs; reset forces every stage to a bubble
   always_comb begin
      stage_stall = '0;
      stage_flush = '1;
      redir_ready = 1'b0;
      fetch_flush = 1'b0;
      flush_pc    = '0;
      if (!rst) begin
         for (int i = 0; i < int'(NSTAGE); i++) begin
            stage_stall[i] = hz_up[i] | frz;
            stage_flush[i] = stage_hazard[i] & ~hz_up[i+1] & ~frz;
         end
         redir_ready = any_redir & ~dn_stall;
         fetch_flush = redir_ready;
         flush_pc    = win_pc;
         // Younger stages hold wrong-path work once a redirect is taken
         if (redir_ready) begin
            for (int i = 0; i < int'(EX_STAGE); i++) begin
               stage_stall[i] = 1'b0;
               stage_flush[i] = 1'b1;
            end
         end
         // While draining, fetch is frozen and feeds bubbles downstream
         if (state_q == StDrain) begin
            stage_stall[0] = 1'b1;
            stage_flush[0] = 1'b1;
         end
      end
   end

   // Debug halt FSM with registered halted flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         dbg_halted <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (dbg_halt_req) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               if (drained) begin
                  state_q    <= StHalted;
                  dbg_halted <= 1'b1;
               end
            end
            StHalted: begin
               if (dbg_resume_req) begin
                  state_q    <= StResume;
                  dbg_halted <= 1'b0;
               end
            end
            StResume: begin
               state_q <= StRun;
            end
            default: begin
               state_q    <= StRun;
               dbg_halted <= 1'b0;
            end
         endcase
      end
   end

   assign wdog_inc = ((state_q == StRun) || (state_q == StDrain)) & (|stage_stall);

   // Stall watchdog: saturating run-length counter with a sticky trip flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt_q   <= '0;
         wdog_timeout <= 1'b0;
      end else if (wdog_inc) begin
         if (wdog_cnt_q != '1) begin
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
         end
         if (wdog_cnt_q == WdogLast) begin
            wdog_timeout <= 1'b1;
         end
      end else begin
         wdog_cnt_q <= '0;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit (NSTAGE=5, EX_STAGE=2, NREDIR=2, WDOG_LIMIT=8).
module tb_pipe_ctrl_unit;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned NSTAGE = 5;
   localparam int unsigned NREDIR = 2;

   logic                     clk;
   logic                     rst;
   logic [NSTAGE-1:0]        stage_hazard;
   logic [NSTAGE-1:0]        stage_valid;
   logic [NREDIR-1:0]        redir_valid;
   logic [NREDIR*ADDR_W-1:0] redir_pc;
   logic                     redir_ready;
   logic                     fetch_flush;
   logic [ADDR_W-1:0]        flush_pc;
   logic [NSTAGE-1:0]        stage_stall;
   logic [NSTAGE-1:0]        stage_flush;
   logic                     dbg_halt_req;
   logic                     dbg_resume_req;
   logic                     dbg_halted;
   logic                     wdog_timeout;

   typedef struct {
      string       name;
      logic [4:0]  stall;
      logic [4:0]  flush;
      logic        ready;
      logic        ff;
      logic [31:0] pc;
      logic        halted;
      logic        wdog;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   failures;
   bit   stim_done;

   pipe_ctrl_unit #(
      .ADDR_W    (ADDR_W),
      .NSTAGE    (NSTAGE),
      .EX_STAGE  (2),
      .NREDIR    (NREDIR),
      .WDOG_W    (16),
      .WDOG_LIMIT(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stage_hazard  (stage_hazard),
      .stage_valid   (stage_valid),
      .redir_valid   (redir_valid),
      .redir_pc      (redir_pc),
      .redir_ready   (redir_ready),
      .fetch_flush   (fetch_flush),
      .flush_pc      (flush_pc),
      .stage_stall   (stage_stall),
      .stage_flush   (stage_flush),
      .dbg_halt_req  (dbg_halt_req),
      .dbg_resume_req(dbg_resume_req),
      .dbg_halted    (dbg_halted),
      .wdog_timeout  (wdog_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of stimulus just after the edge and queue its expected response
   task automatic step(input string nm, input logic r, input logic [4:0] hz,
                       input logic [4:0] sv, input logic [1:0] rv, input logic hr,
                       input logic rr, input logic [4:0] es, input logic [4:0] ef,
                       input logic er, input logic [31:0] epc, input logic eh,
                       input logic ew);
      exp_t e;
      @(posedge clk);
      #1;
      rst            = r;
      stage_hazard   = hz;
      stage_valid    = sv;
      redir_valid    = rv;
      dbg_halt_req   = hr;
      dbg_resume_req = rr;
      e.name   = nm;
      e.stall  = es;
      e.flush  = ef;
      e.ready  = er;
      e.ff     = er;
      e.pc     = epc;
      e.halted = eh;
      e.wdog   = ew;
      sb.push_back(e);
   endtask

   // Monitor: compare the DUT's response mid-cycle against the oldest queued expectation
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         checks = checks + 1;
         if (stage_stall !== e.stall || stage_flush !== e.flush || redir_ready !== e.ready ||
             fetch_flush !== e.ff || flush_pc !== e.pc || dbg_halted !== e.halted ||
             wdog_timeout !== e.wdog) begin
            failures = failures + 1;
            $display("FAIL %s: got stall=%b flush=%b rdy=%b ff=%b pc=%h halted=%b wdog=%b exp stall=%b flush=%b rdy=%b ff=%b pc=%h halted=%b wdog=%b",
                     e.name, stage_stall, stage_flush, redir_ready, fetch_flush, flush_pc,
                     dbg_halted, wdog_timeout, e.stall, e.flush, e.ready, e.ff, e.pc,
                     e.halted, e.wdog);
         end
      end
   end

   initial begin
      checks         = 0;
      failures       = 0;
      stim_done      = 1'b0;
      rst            = 1'b1;
      stage_hazard   = '0;
      stage_valid    = '0;
      redir_valid    = '0;
      redir_pc       = {32'h0000_0200, 32'h0000_0100};
      dbg_halt_req   = 1'b0;
      dbg_resume_req = 1'b0;

      //   name            rst hazard    valid     rv     hr   rr    stall     flush     rdy  pc            h    w
      step("reset",        1, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000, 5'b11111, 0, 32'h0,   0, 0);
      step("idle",         0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 0);
      step("hz_single",    0, 5'b00010, 5'b00000, 2'b00, 0, 0, 5'b00011, 5'b00010, 0, 32'h0,   0, 0);
      step("hz_double",    0, 5'b01010, 5'b00000, 2'b00, 0, 0, 5'b01111, 5'b01000, 0, 32'h0,   0, 0);
      step("hz_clear",     0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 0);
      step("redir_both",   0, 5'b00010, 5'b00000, 2'b11, 0, 0, 5'b00000, 5'b00011, 1, 32'h200, 0, 0);
      step("redir_block",  0, 5'b10010, 5'b00000, 2'b11, 0, 0, 5'b11111, 5'b10000, 0, 32'h200, 0, 0);
      step("redir_lo",     0, 5'b00000, 5'b00000, 2'b01, 0, 0, 5'b00000, 5'b00011, 1, 32'h100, 0, 0);
      step("halt_req",     0, 5'b00000, 5'b11110, 2'b00, 1, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 0);
      step("drain",        0, 5'b00000, 5'b11110, 2'b00, 0, 0, 5'b00001, 5'b00001, 0, 32'h0,   0, 0);
      step("drain_redir",  0, 5'b00000, 5'b01100, 2'b01, 0, 0, 5'b00001, 5'b00011, 1, 32'h100, 0, 0);
      step("drain_empty",  0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00001, 5'b00001, 0, 32'h0,   0, 0);
      step("halted",       0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b11111, 5'b00000, 0, 32'h0,   1, 0);
      step("halted_redir", 0, 5'b00000, 5'b00000, 2'b01, 0, 0, 5'b11111, 5'b00000, 0, 32'h100, 1, 0);
      step("resume_req",   0, 5'b00000, 5'b00000, 2'b00, 0, 1, 5'b11111, 5'b00000, 0, 32'h0,   1, 0);
      step("resume",       0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 0);
      step("run_again",    0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 0);
      for (int k = 0; k < 8; k++) begin
         step("wdog_stall", 0, 5'b01000, 5'b00000, 2'b00, 0, 0, 5'b01111, 5'b01000, 0, 32'h0, 0, 0);
      end
      step("wdog_trip",    0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 1);
      step("wdog_sticky",  0, 5'b00000, 5'b00000, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 1);
      step("halt_again",   0, 5'b00000, 5'b11110, 2'b00, 1, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 1);
      step("drain_rst",    1, 5'b00000, 5'b11110, 2'b00, 0, 0, 5'b00000, 5'b11111, 0, 32'h0,   0, 1);
      step("post_rst",     0, 5'b00000, 5'b11110, 2'b00, 0, 0, 5'b00000, 5'b00000, 0, 32'h0,   0, 0);
      step("post_rst_run", 0, 5'b00010, 5'b11110, 2'b00, 0, 0, 5'b00011, 5'b00010, 0, 32'h0,   0, 0);
      stim_done = 1'b1;
   end

   // Wait for the scoreboard to drain, with a bounded cycle budget
   initial begin
      int budget;
      budget = 0;
      while (!(stim_done && sb.size() == 0) && budget < 500) begin
         @(posedge clk);
         budget = budget + 1;
      end
      if (sb.size() != 0 || !stim_done) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
      end
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
